// File: rtl/axi_spi_regs_if.sv
// -----------------------------------------------------------------------------
// axi_spi_regs_if
// AXI4-Lite bus bundle for the SPI register front end.
//   aw*  : write address channel   (awaddr, awvalid  -> / <- awready)
//   w*   : write data channel      (wdata, wstrb, wvalid -> / <- wready)
//   b*   : write response channel  (<- bresp, bvalid / bready ->)
//   ar*  : read address channel    (araddr, arvalid  -> / <- arready)
//   r*   : read data channel       (<- rdata, rresp, rvalid / rready ->)
// Modports: master drives requests, slave drives readys and responses.
// -----------------------------------------------------------------------------
interface axi_spi_regs_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]  awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [REG_WIDTH-1:0]   wdata;
    logic [REG_WIDTH/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ADDR_WIDTH-1:0]  araddr;
    logic                   arvalid;
    logic                   arready;
    logic [REG_WIDTH-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_spi_regs.sv
// -----------------------------------------------------------------------------
// axi_spi_regs
// AXI4-Lite slave register front end for the SPI controller.
// Ports:
//   iclk, irst_n            clock, asynchronous active-low reset
//   s_axi                   AXI4-Lite slave bus (axi_spi_regs_if.slave)
//   ocontrol_*              CONTROL bits and one-cycle FIFO reset pulses
//   oslave_select           SSR[0]
//   istatus                 controller status word
//   otx_req/otx_data/itx_ack             TX FIFO push handshake
//   orx_req/irx_data/irx_resp/orx_ack    RX FIFO pop handshake
//   itx_occupancy/irx_occupancy          FIFO fill levels
// Register map (addr[4:2]): 0 CONTROL, 1 STATUS, 2 SSR, 3 TX_DATA,
// 4 RX_DATA, 5 TX_OCC, 6 RX_OCC; anything else reads 0 and ignores writes.
// DATA_WIDTH must be at least 7 so the captured write byte covers CONTROL.
// -----------------------------------------------------------------------------
module axi_spi_regs #(
    parameter int ADDR_WIDTH      = 5,
    parameter int REG_WIDTH       = 32,
    parameter int DATA_WIDTH      = 8,
    parameter int SR_RX_EMPTY_BIT = 0,
    parameter int SR_TX_FULL_BIT  = 3
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    axi_spi_regs_if.slave         s_axi,
    output logic                  ocontrol_spi_enable,
    output logic                  ocontrol_master,
    output logic                  ocontrol_cpol,
    output logic                  ocontrol_cpha,
    output logic                  ocontrol_lsb,
    output logic                  ocontrol_tx_fifo_reset,
    output logic                  ocontrol_rx_fifo_reset,
    output logic                  oslave_select,
    input  logic [REG_WIDTH-1:0]  istatus,
    output logic                  otx_req,
    output logic [DATA_WIDTH-1:0] otx_data,
    input  logic                  itx_ack,
    output logic                  orx_req,
    input  logic [DATA_WIDTH-1:0] irx_data,
    input  logic                  irx_resp,
    output logic                  orx_ack,
    input  logic [REG_WIDTH-1:0]  itx_occupancy,
    input  logic [REG_WIDTH-1:0]  irx_occupancy
);
    localparam logic [2:0] A_CONTROL = 3'd0, A_STATUS = 3'd1, A_SSR = 3'd2, A_TX_DATA = 3'd3,
                           A_RX_DATA = 3'd4, A_TX_OCC = 3'd5, A_RX_OCC = 3'd6;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_t;

    // ---------------- write side ----------------
    w_state_t              r_wstate, w_wstate_next;
    logic                  r_awready, w_awready_next, r_wready, w_wready_next;
    logic                  r_aw_done, w_aw_done_next, r_w_done, w_w_done_next;
    logic [2:0]            r_waddr, w_waddr_next;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_next;
    logic                  r_wstrb0, w_wstrb0_next;
    logic                  r_bvalid, w_bvalid_next;
    logic [1:0]            r_bresp, w_bresp_next;
    logic                  r_tx_req, w_tx_req_next;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_next;
    logic [4:0]            r_ctrl, w_ctrl_next;
    logic                  r_ssr, w_ssr_next, r_tx_rst, w_tx_rst_next, r_rx_rst, w_rx_rst_next;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_wstate <= W_IDLE;  r_awready <= 1'b0; r_wready <= 1'b0;
            r_aw_done <= 1'b0;   r_w_done <= 1'b0;  r_waddr <= '0;
            r_wdata <= '0;       r_wstrb0 <= 1'b0;  r_bvalid <= 1'b0;
            r_bresp <= '0;       r_tx_req <= 1'b0;  r_tx_data <= '0;
            r_ctrl <= '0;        r_ssr <= 1'b0;     r_tx_rst <= 1'b0;
            r_rx_rst <= 1'b0;
        end else begin
            r_wstate <= w_wstate_next;   r_awready <= w_awready_next; r_wready <= w_wready_next;
            r_aw_done <= w_aw_done_next; r_w_done <= w_w_done_next;   r_waddr <= w_waddr_next;
            r_wdata <= w_wdata_next;     r_wstrb0 <= w_wstrb0_next;   r_bvalid <= w_bvalid_next;
            r_bresp <= w_bresp_next;     r_tx_req <= w_tx_req_next;   r_tx_data <= w_tx_data_next;
            r_ctrl <= w_ctrl_next;       r_ssr <= w_ssr_next;         r_tx_rst <= w_tx_rst_next;
            r_rx_rst <= w_rx_rst_next;
        end
    end

    always_comb begin
        w_wstate_next  = r_wstate;  w_awready_next = r_awready; w_wready_next  = r_wready;
        w_aw_done_next = r_aw_done; w_w_done_next  = r_w_done;  w_waddr_next   = r_waddr;
        w_wdata_next   = r_wdata;   w_wstrb0_next  = r_wstrb0;  w_bvalid_next  = r_bvalid;
        w_bresp_next   = r_bresp;   w_tx_req_next  = r_tx_req;  w_tx_data_next = r_tx_data;
        w_ctrl_next    = r_ctrl;    w_ssr_next     = r_ssr;
        w_tx_rst_next  = 1'b0;      // FIFO resets are single-cycle pulses
        w_rx_rst_next  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                // AW and W are captured independently; each ready drops after its own handshake.
                if (s_axi.awvalid && r_awready) begin
                    w_waddr_next   = s_axi.awaddr[4:2];
                    w_aw_done_next = 1'b1;
                end
                if (s_axi.wvalid && r_wready) begin
                    w_wdata_next  = s_axi.wdata[DATA_WIDTH-1:0];
                    w_wstrb0_next = s_axi.wstrb[0];
                    w_w_done_next = 1'b1;
                end
                w_awready_next = !w_aw_done_next;
                w_wready_next  = !w_w_done_next;
                if (w_aw_done_next && w_w_done_next) begin
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                    w_wstate_next  = W_EXEC;
                end
            end
            W_EXEC: begin
                w_bresp_next = RESP_OKAY;
                if (!r_wstrb0) begin
                    w_wstate_next = W_RESP;
                end else begin
                    case (r_waddr)
                        A_CONTROL: begin
                            w_ctrl_next   = r_wdata[4:0];
                            w_tx_rst_next = r_wdata[5];
                            w_rx_rst_next = r_wdata[6];
                            w_wstate_next = W_RESP;
                        end
                        A_SSR: begin
                            w_ssr_next    = r_wdata[0];
                            w_wstate_next = W_RESP;
                        end
                        A_TX_DATA: begin
                            // Full is only judged before the request goes out; once pushing, wait for ack.
                            if (!r_tx_req) begin
                                if (istatus[SR_TX_FULL_BIT]) begin
                                    w_bresp_next  = RESP_SLVERR;
                                    w_wstate_next = W_RESP;
                                end else begin
                                    w_tx_req_next  = 1'b1;
                                    w_tx_data_next = r_wdata;
                                end
                            end else if (itx_ack) begin
                                w_tx_req_next = 1'b0;
                                w_wstate_next = W_RESP;
                            end
                        end
                        default: w_wstate_next = W_RESP;
                    endcase
                end
            end
            W_RESP: begin
                w_bvalid_next = 1'b1;
                if (r_bvalid && s_axi.bready) begin
                    w_bvalid_next  = 1'b0;
                    w_awready_next = 1'b1;
                    w_wready_next  = 1'b1;
                    w_wstate_next  = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // ---------------- read side ----------------
    r_state_t             r_rstate, w_rstate_next;
    logic                 r_arready, w_arready_next;
    logic [2:0]           r_raddr, w_raddr_next;
    logic                 r_rvalid, w_rvalid_next;
    logic [1:0]           r_rresp, w_rresp_next;
    logic [REG_WIDTH-1:0] r_rdata, w_rdata_next, w_reg_rdata;
    logic                 r_rx_req, w_rx_req_next, r_rx_ack, w_rx_ack_next;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_rstate <= R_IDLE; r_arready <= 1'b0; r_raddr <= '0;    r_rvalid <= 1'b0;
            r_rresp <= '0;      r_rdata <= '0;     r_rx_req <= 1'b0; r_rx_ack <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next; r_arready <= w_arready_next; r_raddr <= w_raddr_next;
            r_rvalid <= w_rvalid_next; r_rresp <= w_rresp_next;     r_rdata <= w_rdata_next;
            r_rx_req <= w_rx_req_next; r_rx_ack <= w_rx_ack_next;
        end
    end

    always_comb begin
        w_rstate_next = r_rstate; w_arready_next = r_arready; w_raddr_next = r_raddr;
        w_rvalid_next = r_rvalid; w_rresp_next   = r_rresp;   w_rdata_next = r_rdata;
        w_rx_req_next = r_rx_req; w_rx_ack_next  = 1'b0;
        case (r_raddr)
            A_CONTROL: w_reg_rdata = {{(REG_WIDTH-5){1'b0}}, r_ctrl};
            A_STATUS:  w_reg_rdata = istatus;
            A_SSR:     w_reg_rdata = {{(REG_WIDTH-1){1'b0}}, r_ssr};
            A_TX_OCC:  w_reg_rdata = itx_occupancy;
            A_RX_OCC:  w_reg_rdata = irx_occupancy;
            default:   w_reg_rdata = '0;   // TX_DATA is write-only, unmapped reads 0
        endcase
        case (r_rstate)
            R_IDLE: begin
                w_arready_next = 1'b1;
                if (s_axi.arvalid && r_arready) begin
                    w_raddr_next   = s_axi.araddr[4:2];
                    w_arready_next = 1'b0;
                    w_rstate_next  = R_EXEC;
                end
            end
            R_EXEC: begin
                if (r_raddr == A_RX_DATA) begin
                    if (!r_rx_req) begin
                        if (istatus[SR_RX_EMPTY_BIT]) begin
                            w_rdata_next  = '0;
                            w_rresp_next  = RESP_SLVERR;
                            w_rstate_next = R_RESP;
                        end else begin
                            w_rx_req_next = 1'b1;
                        end
                    end else if (irx_resp) begin
                        w_rdata_next  = {{(REG_WIDTH-DATA_WIDTH){1'b0}}, irx_data};
                        w_rresp_next  = RESP_OKAY;
                        w_rx_req_next = 1'b0;
                        w_rx_ack_next = 1'b1;
                        w_rstate_next = R_RESP;
                    end
                end else begin
                    w_rdata_next  = w_reg_rdata;
                    w_rresp_next  = RESP_OKAY;
                    w_rstate_next = R_RESP;
                end
            end
            R_RESP: begin
                w_rvalid_next = 1'b1;
                if (r_rvalid && s_axi.rready) begin
                    w_rvalid_next  = 1'b0;
                    w_arready_next = 1'b1;
                    w_rstate_next  = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Byte-lane and sub-word address bits that the register map never looks at.
    logic w_unused;
    assign w_unused = &{1'b0, s_axi.wdata[REG_WIDTH-1:DATA_WIDTH], s_axi.wstrb[REG_WIDTH/8-1:1],
                        s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;

    assign ocontrol_spi_enable    = r_ctrl[0];
    assign ocontrol_master        = r_ctrl[1];
    assign ocontrol_cpol          = r_ctrl[2];
    assign ocontrol_cpha          = r_ctrl[3];
    assign ocontrol_lsb           = r_ctrl[4];
    assign ocontrol_tx_fifo_reset = r_tx_rst;
    assign ocontrol_rx_fifo_reset = r_rx_rst;
    assign oslave_select          = r_ssr;
    assign otx_req                = r_tx_req;
    assign otx_data               = r_tx_data;
    assign orx_req                = r_rx_req;
    assign orx_ack                = r_rx_ack;
endmodule
